// File: rtl/d8_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : d8_fetch
//  Purpose  : Instruction fetch stage of the dumb8 pipeline. Owns the program
//             counter, drives a synchronous-read instruction memory and fills
//             the LI/DI pipeline latch. Honours the hazard-handler stall (en)
//             and the execute-stage jump redirect (br_valid/br_target). A
//             one-entry skid register preserves the in-flight memory word
//             when a stall arrives while a read is outstanding.
//  Ports    : sys_clk, sys_rst (async, active high)
//             en          - advance enable (1 = LI/DI may load)
//             br_valid    - jump taken, br_target = destination
//             imem_adr    - memory address (= pc)
//             imem_en     - read strobe, data returns next cycle
//             imem_dat    - read data {op, a, b, c}
//             li_di_op/a/b/c - registered LI/DI latch
//  Revision : 1.0 - initial release
// ============================================================================
module d8_fetch (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic        br_valid,
  input  logic [7:0]  br_target,
  output logic [7:0]  imem_adr,
  output logic        imem_en,
  input  logic [31:0] imem_dat,
  output logic [7:0]  li_di_op,
  output logic [7:0]  li_di_a,
  output logic [7:0]  li_di_b,
  output logic [7:0]  li_di_c
);

  localparam logic [31:0] C_NOP = 32'h0000_0000;

  logic [7:0]  r_pc;
  logic        r_pend;      // read issued last cycle, imem_dat valid now
  logic        r_skid_v;
  logic [31:0] r_skid_dat;
  logic [31:0] r_li_di;

  assign imem_adr = r_pc;
  // Gated by reset so no read strobe escapes while state is being cleared.
  assign imem_en  = ~sys_rst & ~br_valid & en;

  assign li_di_op = r_li_di[31:24];
  assign li_di_a  = r_li_di[23:16];
  assign li_di_b  = r_li_di[15:8];
  assign li_di_c  = r_li_di[7:0];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_pc       <= 8'h00;
      r_pend     <= 1'b0;
      r_skid_v   <= 1'b0;
      r_skid_dat <= C_NOP;
      r_li_di    <= C_NOP;
    end else if (br_valid) begin
      // Flush: discard both the outstanding read and any skidded word.
      r_li_di  <= C_NOP;
      r_pc     <= br_target;
      r_pend   <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (en) begin
      if (r_skid_v)
        r_li_di <= r_skid_dat;
      else if (r_pend)
        r_li_di <= imem_dat;
      else
        r_li_di <= C_NOP;
      r_skid_v <= 1'b0;
      r_pend   <= 1'b1;
      r_pc     <= r_pc + 8'd1;   // 8-bit modulo wrap
    end else begin
      // Hold: park the word returning this cycle so it is not lost.
      if (r_pend) begin
        r_skid_dat <= imem_dat;
        r_skid_v   <= 1'b1;
        r_pend     <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_d8_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_d8_fetch
//  Purpose  : Directed self-checking bench for d8_fetch. Expected LI/DI and
//             address values are pushed to a scoreboard queue as each step is
//             driven and popped/compared after the clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_d8_fetch;

  logic        clk;
  logic        rst;
  logic        en;
  logic        br_valid;
  logic [7:0]  br_target;
  logic [7:0]  imem_adr;
  logic        imem_en;
  logic [31:0] imem_dat;
  logic [7:0]  li_di_op, li_di_a, li_di_b, li_di_c;

  int n_cmp;
  int n_mis;

  logic [39:0] sb_q[$];   // {expected imem_adr, expected li_di word}

  d8_fetch dut (
    .sys_clk   (clk),
    .sys_rst   (rst),
    .en        (en),
    .br_valid  (br_valid),
    .br_target (br_target),
    .imem_adr  (imem_adr),
    .imem_en   (imem_en),
    .imem_dat  (imem_dat),
    .li_di_op  (li_di_op),
    .li_di_a   (li_di_a),
    .li_di_b   (li_di_b),
    .li_di_c   (li_di_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [7:0] a);
    logic [7:0] a1;
    logic [7:0] a2;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    return {8'h01, a, a1, a2};
  endfunction

  // Synchronous-read instruction memory model.
  initial imem_dat = 32'h0;
  always @(posedge clk) begin
    if (imem_en)
      imem_dat <= rom(imem_adr);
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] li_word();
    return {li_di_op, li_di_a, li_di_b, li_di_c};
  endfunction

  // One clock step: drive inputs, check the read strobe before the edge,
  // then compare the LI/DI latch and address after the edge.
  task automatic step(input string tag, input logic s_en, input logic s_br,
                      input logic [7:0] s_tgt, input logic [31:0] exp_li,
                      input logic [7:0] exp_adr);
    logic [39:0] e;
    en        = s_en;
    br_valid  = s_br;
    br_target = s_tgt;
    sb_q.push_back({exp_adr, exp_li});
    #1;
    check({tag, ".imem_en"}, {39'h0, imem_en}, {39'h0, (s_en & ~s_br)});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(tag, {imem_adr, li_word()}, e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".li"},  {8'h0, li_word()}, 40'h0);
    check({tag, ".adr"}, {32'h0, imem_adr}, 40'h0);
    check({tag, ".en"},  {39'h0, imem_en},  40'h0);
  endtask

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    rst       = 1'b1;
    en        = 1'b1;
    br_valid  = 1'b0;
    br_target = 8'h00;
    #2;
    check_reset_state("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Cold start: E0 reads 0 with NOP latch, then instr k after E(k+1).
    step("cold.E0", 1, 0, 8'h00, 32'h0,    8'h01);
    for (int k = 0; k < 4; k++)
      step("cold", 1, 0, 8'h00, rom(8'(k)), 8'(k + 2));

    // Stall for 3 cycles while instr[4] is in flight.
    for (int k = 0; k < 3; k++)
      step("stall.hold", 0, 0, 8'h00, rom(8'd3), 8'h05);
    step("stall.skid", 1, 0, 8'h00, rom(8'd4), 8'h06);
    step("stall.next", 1, 0, 8'h00, rom(8'd5), 8'h07);
    step("stall.next", 1, 0, 8'h00, rom(8'd6), 8'h08);

    // Jump to 0x40: two bubbles, then instr[0x40].
    step("jmp.flush",  1, 1, 8'h40, 32'h0,      8'h40);
    step("jmp.bubble", 1, 0, 8'h00, 32'h0,      8'h41);
    step("jmp.tgt",    1, 0, 8'h00, rom(8'h40), 8'h42);
    step("jmp.tgt1",   1, 0, 8'h00, rom(8'h41), 8'h43);

    // Jump while stalled with a skidded word: skid must be discarded.
    step("jskid.hold",   0, 0, 8'h00, rom(8'h41), 8'h43);
    step("jskid.flush",  0, 1, 8'h80, 32'h0,      8'h80);
    step("jskid.bubble", 1, 0, 8'h00, 32'h0,      8'h81);
    step("jskid.tgt",    1, 0, 8'h00, rom(8'h80), 8'h82);
    step("jskid.tgt1",   1, 0, 8'h00, rom(8'h81), 8'h83);

    // Wrap: FE, FF, 00, 01 in order.
    step("wrap.flush",  1, 1, 8'hFE, 32'h0,      8'hFE);
    step("wrap.bubble", 1, 0, 8'h00, 32'h0,      8'hFF);
    step("wrap.FE",     1, 0, 8'h00, rom(8'hFE), 8'h00);
    step("wrap.FF",     1, 0, 8'h00, rom(8'hFF), 8'h01);
    step("wrap.00",     1, 0, 8'h00, rom(8'h00), 8'h02);
    step("wrap.01",     1, 0, 8'h00, rom(8'h01), 8'h03);

    // Branch held two cycles: last target wins.
    step("br2.first",  1, 1, 8'h10, 32'h0,      8'h10);
    step("br2.second", 1, 1, 8'h20, 32'h0,      8'h20);
    step("br2.bubble", 1, 0, 8'h00, 32'h0,      8'h21);
    step("br2.tgt",    1, 0, 8'h00, rom(8'h20), 8'h22);

    // Reset mid-stall, asserted between edges.
    step("rst.hold", 0, 0, 8'h00, rom(8'h20), 8'h22);
    rst = 1'b1;
    en  = 1'b1;
    #1;
    check_reset_state("rst.async");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step("rst.E0", 1, 0, 8'h00, 32'h0, 8'h01);
    for (int k = 0; k < 3; k++)
      step("rst.cold", 1, 0, 8'h00, rom(8'(k)), 8'(k + 2));

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL scoreboard: %0d entries left, 0 required", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, run did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
